// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forward-select encodings, Tuse values, Tnew width
// and a helper that sizes the MDU busy counter.
package hazard_scoreboard_pkg;

    localparam int unsigned TNEW_W = 2;
    typedef logic [TNEW_W-1:0] tnew_t;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_M    = 2'd1;
    localparam logic [1:0] FWD_W    = 2'd2;
    localparam logic [1:0] FWD_E    = 2'd3;

    localparam tnew_t TUSE_D = 2'd0;
    localparam tnew_t TUSE_E = 2'd1;
    localparam tnew_t TUSE_M = 2'd2;

    // Wide enough for the longer of the two MDU latencies.
    function automatic int unsigned cnt_width(int unsigned mul_cycles, int unsigned div_cycles);
        int unsigned longest;
        longest = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and hazard-control response bundle of the hazard scoreboard.
// Define HAZARD_STATS_EN to add the three 32-bit statistics outputs.
interface hazard_scoreboard_if
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5
);
    logic [NUM_SRC*REG_AW-1:0] src_addr_d;
    logic [NUM_SRC*2-1:0]      src_tuse_d;
    logic [REG_AW-1:0]         dst_addr_d;
    logic                      dst_we_d;
    tnew_t                     dst_tnew_d;
    logic                      mdu_use_d;
    logic                      mdu_start_e;
    logic                      mdu_div_e;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_e;
    logic [NUM_SRC*2-1:0]      fwd_d;
    logic [NUM_SRC*2-1:0]      fwd_e;
    logic                      mdu_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0]               stall_cnt;
    logic [31:0]               mdu_stall_cnt;
    logic [31:0]               fwd_cnt;
`endif

    modport slave (
        input  src_addr_d, src_tuse_d, dst_addr_d, dst_we_d, dst_tnew_d,
        input  mdu_use_d, mdu_start_e, mdu_div_e,
        output stall_f, stall_d, flush_e, fwd_d, fwd_e, mdu_busy
`ifdef HAZARD_STATS_EN
        , output stall_cnt, mdu_stall_cnt, fwd_cnt
`endif
    );

    modport master (
        output src_addr_d, src_tuse_d, dst_addr_d, dst_we_d, dst_tnew_d,
        output mdu_use_d, mdu_start_e, mdu_div_e,
        input  stall_f, stall_d, flush_e, fwd_d, fwd_e, mdu_busy
`ifdef HAZARD_STATS_EN
        , input stall_cnt, mdu_stall_cnt, fwd_cnt
`endif
    );

endinterface

// File: rtl/hazard_mdu_timer.sv
// Multi-cycle mult/div busy timer: loads the operation latency on launch and counts down to idle.
module hazard_mdu_timer
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic div,
    output logic busy
);
    localparam int unsigned CNT_W = cnt_width(MUL_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] cnt;

    // A launch while busy is ignored; the D-stage stall keeps it from happening.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start && !busy) begin
            cnt <= div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the 5-stage core: E/M/W destination records compared against
// D/E sources using Tuse/Tnew timing, plus MDU stall. HAZARD_STATS_EN adds stall/forward counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hz
);
    logic [REG_AW-1:0]         e_addr, m_addr, w_addr;
    logic                      e_we, m_we, w_we;
    tnew_t                     e_tnew, m_tnew;
    logic [NUM_SRC*REG_AW-1:0] e_src;
    logic [NUM_SRC-1:0]        src_stall;
    logic [NUM_SRC*2-1:0]      fwd_d, fwd_e;
    logic                      mdu_busy, mdu_stall, stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] a_d, a_e;
        tnew_t             tuse;
        logic              hit_e, hit_m, hit_em, hit_ew;

        assign a_d    = hz.src_addr_d[i*REG_AW +: REG_AW];
        assign a_e    = e_src[i*REG_AW +: REG_AW];
        assign tuse   = hz.src_tuse_d[i*2 +: 2];
        assign hit_e  = (a_d != '0) && e_we && (a_d == e_addr);
        assign hit_m  = (a_d != '0) && m_we && (a_d == m_addr);
        assign hit_em = (a_e != '0) && m_we && (a_e == m_addr);
        assign hit_ew = (a_e != '0) && w_we && (a_e == w_addr);

        assign src_stall[i] = (hit_e && (e_tnew > tuse)) || (hit_m && (m_tnew > tuse));

        // The youngest match decides; if its result is not ready, older producers stay hidden.
        assign fwd_d[i*2 +: 2] = hit_e ? ((e_tnew == '0) ? FWD_E : FWD_NONE) :
                                 (hit_m && (m_tnew == '0)) ? FWD_M : FWD_NONE;
        assign fwd_e[i*2 +: 2] = hit_em ? ((m_tnew == '0) ? FWD_M : FWD_NONE) :
                                 hit_ew ? FWD_W : FWD_NONE;
    end

    hazard_mdu_timer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_mdu_timer (
        .clk  (clk),
        .reset(reset),
        .start(hz.mdu_start_e),
        .div  (hz.mdu_div_e),
        .busy (mdu_busy)
    );

    assign mdu_stall = hz.mdu_use_d && (mdu_busy || hz.mdu_start_e);
    assign stall     = (|src_stall) || mdu_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_addr <= '0;
            e_we   <= 1'b0;
            e_tnew <= '0;
            e_src  <= '0;
            m_addr <= '0;
            m_we   <= 1'b0;
            m_tnew <= '0;
            w_addr <= '0;
            w_we   <= 1'b0;
        end else begin
            w_addr <= m_addr;
            w_we   <= m_we;
            m_addr <= e_addr;
            m_we   <= e_we;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - tnew_t'(1);
            if (stall) begin
                e_addr <= '0;
                e_we   <= 1'b0;
                e_tnew <= '0;
                e_src  <= '0;
            end else begin
                e_addr <= hz.dst_addr_d;
                e_we   <= hz.dst_we_d;
                e_tnew <= hz.dst_tnew_d;
                e_src  <= hz.src_addr_d;
            end
        end
    end

    assign hz.stall_f  = stall;
    assign hz.stall_d  = stall;
    assign hz.flush_e  = stall;
    assign hz.fwd_d    = fwd_d;
    assign hz.fwd_e    = fwd_e;
    assign hz.mdu_busy = mdu_busy;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_ctr, mdu_stall_ctr, fwd_ctr;
    logic        fwd_any;

    assign fwd_any = (fwd_d != '0) || (fwd_e != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_ctr     <= '0;
            mdu_stall_ctr <= '0;
            fwd_ctr       <= '0;
        end else begin
            if (stall && (stall_ctr != '1)) stall_ctr <= stall_ctr + 32'd1;
            if (mdu_stall && !(|src_stall) && (mdu_stall_ctr != '1)) begin
                mdu_stall_ctr <= mdu_stall_ctr + 32'd1;
            end
            if (fwd_any && (fwd_ctr != '1)) fwd_ctr <= fwd_ctr + 32'd1;
        end
    end

    assign hz.stall_cnt     = stall_ctr;
    assign hz.mdu_stall_cnt = mdu_stall_ctr;
    assign hz.fwd_cnt       = fwd_ctr;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, checked every
// cycle against an in-flight instruction list model (issue time, Tnew) and an MDU busy deadline.
module tb_hazard_scoreboard;
    localparam int NSRC = 2;
    localparam int AW   = 5;
    localparam int MULC = 5;
    localparam int DIVC = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_SRC(NSRC), .REG_AW(AW)) hz ();

    hazard_scoreboard #(
        .NUM_SRC   (NSRC),
        .REG_AW    (AW),
        .MUL_CYCLES(MULC),
        .DIV_CYCLES(DIVC)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .hz   (hz)
    );

    typedef struct {
        int unsigned          issue;
        logic [AW-1:0]        addr;
        logic                 we;
        logic [1:0]           tnew;
        logic [NSRC*AW-1:0]   src;
    } ins_t;

    ins_t        q[$];
    int unsigned now      = 0;
    int unsigned busy_end = 0;
    int          n_checks = 0;
    int          n_pass   = 0;

    logic                exp_stall, exp_src_stall, exp_busy;
    logic [2*NSRC-1:0]   exp_fd, exp_fe;
`ifdef HAZARD_STATS_EN
    logic [31:0] m_stall_cnt = 0, m_mdu_cnt = 0, m_fwd_cnt = 0;
`endif

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    // Hand-computed value checked against both the DUT and the model.
    task automatic lit(string name, logic [31:0] dut_v, logic [31:0] mdl_v, logic [31:0] want);
        check({name, "_dut"}, dut_v, want);
        check({name, "_model"}, mdl_v, want);
    endtask

    // Pipeline stage of an in-flight instruction is its age: 0 = E, 1 = M, 2 = W.
    function automatic int find(int unsigned stage);
        foreach (q[k]) if (now - q[k].issue == stage) return k;
        return -1;
    endfunction

    function automatic logic hit(int idx, logic [AW-1:0] a);
        if (idx < 0) return 1'b0;
        return (a != '0) && q[idx].we && (q[idx].addr == a);
    endfunction

    function automatic logic [1:0] remaining(logic [1:0] tnew, int unsigned age);
        return (int'(tnew) > int'(age)) ? 2'(int'(tnew) - int'(age)) : 2'd0;
    endfunction

    task automatic model_eval();
        int            ie, im, iw;
        logic [AW-1:0] a;
        logic [1:0]    tu;
        ie = find(0);
        im = find(1);
        iw = find(2);
        exp_stall = 1'b0;
        exp_fd    = '0;
        exp_fe    = '0;
        exp_busy  = (now < busy_end);
        for (int i = 0; i < NSRC; i++) begin
            a  = hz.src_addr_d[i*AW +: AW];
            tu = hz.src_tuse_d[i*2 +: 2];
            if (hit(ie, a) && q[ie].tnew > tu) exp_stall = 1'b1;
            if (hit(im, a) && remaining(q[im].tnew, 1) > tu) exp_stall = 1'b1;
            if (hit(ie, a)) begin
                if (q[ie].tnew == 2'd0) exp_fd[i*2 +: 2] = 2'd3;
            end else if (hit(im, a) && remaining(q[im].tnew, 1) == 2'd0) begin
                exp_fd[i*2 +: 2] = 2'd1;
            end
            if (ie >= 0) begin
                a = q[ie].src[i*AW +: AW];
                if (hit(im, a)) begin
                    if (remaining(q[im].tnew, 1) == 2'd0) exp_fe[i*2 +: 2] = 2'd1;
                end else if (hit(iw, a)) begin
                    exp_fe[i*2 +: 2] = 2'd2;
                end
            end
        end
        exp_src_stall = exp_stall;
        if (hz.mdu_use_d && (exp_busy || hz.mdu_start_e)) exp_stall = 1'b1;
    endtask

    task automatic model_update();
        ins_t ins;
        if (rst) begin
            q.delete();
            busy_end = 0;
`ifdef HAZARD_STATS_EN
            m_stall_cnt = 0;
            m_mdu_cnt   = 0;
            m_fwd_cnt   = 0;
`endif
        end else begin
`ifdef HAZARD_STATS_EN
            if (exp_stall && m_stall_cnt != '1) m_stall_cnt++;
            if (exp_stall && !exp_src_stall && m_mdu_cnt != '1) m_mdu_cnt++;
            if ((exp_fd != '0 || exp_fe != '0) && m_fwd_cnt != '1) m_fwd_cnt++;
`endif
            if (hz.mdu_start_e && !(now < busy_end)) begin
                busy_end = now + 1 + (hz.mdu_div_e ? DIVC : MULC);
            end
            if (!exp_stall) begin
                ins.issue = now + 1;
                ins.addr  = hz.dst_addr_d;
                ins.we    = hz.dst_we_d;
                ins.tnew  = hz.dst_tnew_d;
                ins.src   = hz.src_addr_d;
                q.push_back(ins);
            end
        end
        now++;
        while (q.size() > 0 && now - q[0].issue > 2) void'(q.pop_front());
    endtask

    task automatic compare();
        check("stall_f", hz.stall_f, exp_stall);
        check("stall_d", hz.stall_d, exp_stall);
        check("flush_e", hz.flush_e, exp_stall);
        check("fwd_d", hz.fwd_d, exp_fd);
        check("fwd_e", hz.fwd_e, exp_fe);
        check("mdu_busy", hz.mdu_busy, exp_busy);
`ifdef HAZARD_STATS_EN
        check("stall_cnt", hz.stall_cnt, m_stall_cnt);
        check("mdu_stall_cnt", hz.mdu_stall_cnt, m_mdu_cnt);
        check("fwd_cnt", hz.fwd_cnt, m_fwd_cnt);
`endif
    endtask

    task automatic settle();
        #1;
        model_eval();
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        hz.src_addr_d  = '0;
        hz.src_tuse_d  = '0;
        hz.dst_addr_d  = '0;
        hz.dst_we_d    = 1'b0;
        hz.dst_tnew_d  = '0;
        hz.mdu_use_d   = 1'b0;
        hz.mdu_start_e = 1'b0;
        hz.mdu_div_e   = 1'b0;
    endtask

    task automatic set_d(logic [AW-1:0] s0, logic [AW-1:0] s1, logic [1:0] t0, logic [1:0] t1,
                         logic [AW-1:0] dst, logic we, logic [1:0] tnew);
        hz.src_addr_d = {s1, s0};
        hz.src_tuse_d = {t1, t0};
        hz.dst_addr_d = dst;
        hz.dst_we_d   = we;
        hz.dst_tnew_d = tnew;
    endtask

    task automatic flush_pipe();
        idle();
        repeat (3) step();
    endtask

    initial begin
        int  stall_cycles, busy_cycles, m_stall_cycles;
        logic done;

        idle();
        rst = 1'b1;
        repeat (2) advance();
        rst = 1'b0;
        settle();
        lit("reset_stall", hz.stall_f, exp_stall, 0);
        lit("reset_busy", hz.mdu_busy, exp_busy, 0);
        advance();

        // lw $8 (tnew 2) then addu $9,$8,$8 (tuse 1)
        flush_pipe();
        set_d(29, 0, 1, 1, 8, 1, 2); step();
        set_d(8, 8, 1, 1, 9, 1, 1);
        settle(); lit("t1_stall", hz.stall_f, exp_stall, 1); advance();
        settle(); lit("t1_release", hz.stall_f, exp_stall, 0);
        lit("t1_fwd_d", hz.fwd_d, exp_fd, 0); advance();
        idle();
        settle(); lit("t1_fwd_e_w", hz.fwd_e, exp_fe, 4'b1010); advance();
        settle(); lit("t1_fwd_e_gone", hz.fwd_e, exp_fe, 0); advance();

        // addu $8 (tnew 1) then beq $8,$0 (tuse 0)
        flush_pipe();
        set_d(1, 2, 1, 1, 8, 1, 1); step();
        set_d(8, 0, 0, 0, 0, 0, 0);
        settle(); lit("t2_stall", hz.stall_f, exp_stall, 1); advance();
        settle(); lit("t2_release", hz.stall_f, exp_stall, 0);
        lit("t2_fwd_d", hz.fwd_d, exp_fd, 4'b0001); advance();

        // jal then jr $31
        flush_pipe();
        set_d(0, 0, 0, 0, 31, 1, 0); step();
        set_d(31, 0, 0, 0, 0, 0, 0);
        settle(); lit("t3_stall", hz.stall_f, exp_stall, 0);
        lit("t3_fwd_d", hz.fwd_d, exp_fd, 4'b0011); advance();

        // two producers of $5: younger ready, then younger not ready
        flush_pipe();
        set_d(0, 0, 0, 0, 5, 1, 0); step();
        set_d(0, 0, 0, 0, 5, 1, 0); step();
        set_d(5, 0, 0, 0, 0, 0, 0);
        settle(); lit("t5a_stall", hz.stall_f, exp_stall, 0);
        lit("t5a_fwd_d", hz.fwd_d, exp_fd, 4'b0011); advance();
        flush_pipe();
        set_d(0, 0, 0, 0, 5, 1, 0); step();
        set_d(0, 0, 0, 0, 5, 1, 1); step();
        set_d(5, 0, 0, 0, 0, 0, 0);
        settle(); lit("t5b_stall", hz.stall_f, exp_stall, 1);
        lit("t5b_fwd_d", hz.fwd_d, exp_fd, 0); advance();

        // div launched in E with mflo in D
        flush_pipe();
        set_d(0, 0, 0, 0, 2, 1, 1);
        hz.mdu_use_d   = 1'b1;
        hz.mdu_start_e = 1'b1;
        hz.mdu_div_e   = 1'b1;
        stall_cycles   = 0;
        busy_cycles    = 0;
        m_stall_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (hz.stall_f === 1'b1) stall_cycles++;
            if (hz.mdu_busy === 1'b1) busy_cycles++;
            if (exp_stall) m_stall_cycles++;
            done = (hz.stall_f !== 1'b1);
            advance();
            hz.mdu_start_e = 1'b0;
            hz.mdu_div_e   = 1'b0;
            if (done) break;
        end
        lit("t4_stall_cycles", stall_cycles, m_stall_cycles, DIVC + 1);
        check("t4_busy_cycles", busy_cycles, DIVC);

        // reset partway through a divide
        flush_pipe();
        set_d(0, 0, 0, 0, 7, 1, 0);
        hz.mdu_start_e = 1'b1;
        hz.mdu_div_e   = 1'b1;
        step();
        hz.mdu_start_e = 1'b0;
        hz.mdu_div_e   = 1'b0;
        set_d(7, 0, 0, 0, 0, 0, 0);
        hz.mdu_use_d = 1'b1;
        settle(); lit("t6_pre_stall", hz.stall_f, exp_stall, 1); advance();
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        lit("t6_busy", hz.mdu_busy, exp_busy, 0);
        lit("t6_stall", hz.stall_f, exp_stall, 0);
        lit("t6_fwd_d", hz.fwd_d, exp_fd, 0);
        lit("t6_fwd_e", hz.fwd_e, exp_fe, 0);
`ifdef HAZARD_STATS_EN
        lit("t6_stall_cnt", hz.stall_cnt, m_stall_cnt, 0);
        lit("t6_mdu_cnt", hz.mdu_stall_cnt, m_mdu_cnt, 0);
        lit("t6_fwd_cnt", hz.fwd_cnt, m_fwd_cnt, 0);
`endif
        advance();

        // random traffic over a small register range so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            hz.src_addr_d  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            hz.src_tuse_d  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
            hz.dst_addr_d  = AW'($urandom_range(0, 7));
            hz.dst_we_d    = ($urandom_range(0, 3) != 0);
            hz.dst_tnew_d  = 2'($urandom_range(0, 3));
            hz.mdu_use_d   = ($urandom_range(0, 3) == 0);
            hz.mdu_start_e = ($urandom_range(0, 7) == 0);
            hz.mdu_div_e   = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
